// File: rtl/dec_wr_arb.sv
// Two-port register-file write arbiter: round-robin grant with a combinational ack,
// then a registered one-hot write-enable decode with an error pulse and conflict statistics.
module dec_wr_arb #(
  parameter  int NREG         = 8,
  parameter  bit ZERO_PROTECT = 1'b0,
  localparam int ADDR_W       = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrenA,
  input  logic [ADDR_W-1:0] writeaddressA,
  output logic              ackA,
  input  logic              wrenB,
  input  logic [ADDR_W-1:0] writeaddressB,
  output logic              ackB,
  output logic [NREG-1:0]   decOut,
  output logic              wsel,
  output logic              addr_err,
  output logic [7:0]        conflict_cnt
);

  logic              r_lastB;
  logic              w_both;
  logic              w_grantA;
  logic              w_grantB;
  logic              w_grant;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic              w_oob;
  logic              w_zero;
  logic [NREG-1:0]   w_onehot;

  logic [NREG-1:0]   r_dec_p1;
  logic              r_wsel_p1;
  logic              r_err_p1;
  logic [7:0]        r_conflict_cnt;

  // Stage p0: arbitration and decode of the winning address
  assign w_both   = wrenA & wrenB;
  // On a conflict the port that did not win last time is granted
  assign w_grantA = ~rst & wrenA & (~wrenB | r_lastB);
  assign w_grantB = ~rst & wrenB & (~wrenA | ~r_lastB);
  assign w_grant  = w_grantA | w_grantB;

  assign w_gnt_addr = w_grantB ? writeaddressB : writeaddressA;
  assign w_oob      = (32'(w_gnt_addr) >= NREG);
  assign w_zero     = ZERO_PROTECT && (w_gnt_addr == '0);

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NREG; i++) begin
      w_onehot[i] = (w_gnt_addr == ADDR_W'(i));
    end
  end

  // Stage p1: registered write enable, port select and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dec_p1       <= '0;
      r_wsel_p1      <= 1'b0;
      r_err_p1       <= 1'b0;
      r_lastB        <= 1'b1;
      r_conflict_cnt <= 8'd0;
    end else begin
      r_dec_p1 <= (w_grant && !w_oob && !w_zero) ? w_onehot : '0;
      r_err_p1 <= w_grant && w_oob;
      if (w_grant) begin
        r_wsel_p1 <= w_grantB;
        r_lastB   <= w_grantB;
      end
      if (w_both && (r_conflict_cnt != 8'hFF)) begin
        r_conflict_cnt <= r_conflict_cnt + 8'd1;
      end
    end
  end

  assign ackA         = w_grantA;
  assign ackB         = w_grantB;
  assign decOut       = r_dec_p1;
  assign wsel         = r_wsel_p1;
  assign addr_err     = r_err_p1;
  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_dec_wr_arb.sv
// Directed bench for dec_wr_arb: three instances (NREG=8, NREG=6, NREG=8 zero-protected)
// share one set of request inputs; each task checks the instance relevant to its scenario.
module tb_dec_wr_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wrenA = 1'b0;
  logic       wrenB = 1'b0;
  logic [2:0] addrA = 3'd0;
  logic [2:0] addrB = 3'd0;

  logic       ackA8, ackB8, wsel8, err8;
  logic [7:0] dec8, cnt8;
  logic       ackA6, ackB6, wsel6, err6;
  logic [5:0] dec6;
  logic [7:0] cnt6;
  logic       ackAz, ackBz, wselz, errz;
  logic [7:0] decz, cntz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dec_wr_arb #(.NREG(8), .ZERO_PROTECT(1'b0)) u8 (
    .clk(clk), .rst(rst),
    .wrenA(wrenA), .writeaddressA(addrA), .ackA(ackA8),
    .wrenB(wrenB), .writeaddressB(addrB), .ackB(ackB8),
    .decOut(dec8), .wsel(wsel8), .addr_err(err8), .conflict_cnt(cnt8)
  );

  dec_wr_arb #(.NREG(6), .ZERO_PROTECT(1'b0)) u6 (
    .clk(clk), .rst(rst),
    .wrenA(wrenA), .writeaddressA(addrA), .ackA(ackA6),
    .wrenB(wrenB), .writeaddressB(addrB), .ackB(ackB6),
    .decOut(dec6), .wsel(wsel6), .addr_err(err6), .conflict_cnt(cnt6)
  );

  dec_wr_arb #(.NREG(8), .ZERO_PROTECT(1'b1)) uz (
    .clk(clk), .rst(rst),
    .wrenA(wrenA), .writeaddressA(addrA), .ackA(ackAz),
    .wrenB(wrenB), .writeaddressB(addrB), .ackB(ackBz),
    .decOut(decz), .wsel(wselz), .addr_err(errz), .conflict_cnt(cntz)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wrenA = 1'b0;
    wrenB = 1'b0;
    rst   = 1'b1;
    tick();
    tick();
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dec8 !== 8'd0) begin errors++; $display("FAIL reset_dec: got %b want %b", dec8, 8'd0); end
    checks++;
    if (wsel8 !== 1'b0) begin errors++; $display("FAIL reset_wsel: got %b want 0", wsel8); end
    checks++;
    if (err8 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err8); end
    checks++;
    if (cnt8 !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt8); end
    checks++;
    if ({ackA8, ackB8} !== 2'b00) begin errors++; $display("FAIL reset_idle_ack: got %b want 00", {ackA8, ackB8}); end
  endtask

  task automatic test_single_a();
    do_reset();
    wrenA = 1'b1; addrA = 3'd5;
    #1;
    checks++;
    if ({ackA8, ackB8} !== 2'b10) begin errors++; $display("FAIL single_ack: got %b want 10", {ackA8, ackB8}); end
    tick();
    wrenA = 1'b0;
    checks++;
    if (dec8 !== 8'b0010_0000) begin errors++; $display("FAIL single_dec: got %b want 00100000", dec8); end
    checks++;
    if (wsel8 !== 1'b0 || err8 !== 1'b0) begin errors++; $display("FAIL single_wsel_err: got %b%b want 00", wsel8, err8); end
    tick();
    checks++;
    if (dec8 !== 8'd0) begin errors++; $display("FAIL single_idle_dec: got %b want 00000000", dec8); end
  endtask

  task automatic test_conflict_drop();
    do_reset();
    wrenA = 1'b1; addrA = 3'd2;
    wrenB = 1'b1; addrB = 3'd6;
    #1;
    checks++;
    if ({ackA8, ackB8} !== 2'b10) begin errors++; $display("FAIL drop_ack1: got %b want 10", {ackA8, ackB8}); end
    tick();
    wrenA = 1'b0;
    checks++;
    if (dec8 !== 8'b0000_0100 || wsel8 !== 1'b0) begin errors++; $display("FAIL drop_dec1: got %b/%b want 00000100/0", dec8, wsel8); end
    #1;
    checks++;
    if ({ackA8, ackB8} !== 2'b01) begin errors++; $display("FAIL drop_ack2: got %b want 01", {ackA8, ackB8}); end
    tick();
    wrenB = 1'b0;
    checks++;
    if (dec8 !== 8'b0100_0000 || wsel8 !== 1'b1) begin errors++; $display("FAIL drop_dec2: got %b/%b want 01000000/1", dec8, wsel8); end
    tick();
    checks++;
    if (dec8 !== 8'd0 || wsel8 !== 1'b1) begin errors++; $display("FAIL drop_idle: got %b/%b want 00000000/1", dec8, wsel8); end
    tick();
    checks++;
    if (cnt8 !== 8'd1) begin errors++; $display("FAIL drop_cnt: got %0d want 1", cnt8); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_dec;
    do_reset();
    wrenA = 1'b1; addrA = 3'd1;
    wrenB = 1'b1; addrB = 3'd3;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if ({ackA8, ackB8} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL b2b_ack[%0d]: got %b want %b", i, {ackA8, ackB8}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      tick();
      exp_dec = (i % 2 == 0) ? 8'b0000_0010 : 8'b0000_1000;
      checks++;
      if (dec8 !== exp_dec || wsel8 !== ((i % 2 == 0) ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL b2b_dec[%0d]: got %b/%b want %b/%b", i, dec8, wsel8, exp_dec, (i % 2 == 0) ? 1'b0 : 1'b1);
      end
    end
    wrenA = 1'b0; wrenB = 1'b0;
    checks++;
    if (cnt8 !== 8'd6) begin errors++; $display("FAIL b2b_cnt: got %0d want 6", cnt8); end
  endtask

  task automatic test_addr_err();
    do_reset();
    wrenB = 1'b1; addrB = 3'd7;
    #1;
    checks++;
    if ({ackA6, ackB6} !== 2'b01) begin errors++; $display("FAIL err_ack: got %b want 01", {ackA6, ackB6}); end
    tick();
    addrB = 3'd5;
    checks++;
    if (dec6 !== 6'd0 || err6 !== 1'b1) begin errors++; $display("FAIL err_oob: got %b/%b want 000000/1", dec6, err6); end
    checks++;
    if (dec8 !== 8'b1000_0000 || err8 !== 1'b0) begin errors++; $display("FAIL err_inrange8: got %b/%b want 10000000/0", dec8, err8); end
    #1;
    checks++;
    if (ackB6 !== 1'b1) begin errors++; $display("FAIL err_ack2: got %b want 1", ackB6); end
    tick();
    wrenB = 1'b0;
    checks++;
    if (dec6 !== 6'b10_0000 || err6 !== 1'b0) begin errors++; $display("FAIL err_top: got %b/%b want 100000/0", dec6, err6); end
    tick();
    checks++;
    if (err6 !== 1'b0 || dec6 !== 6'd0) begin errors++; $display("FAIL err_idle: got %b/%b want 000000/0", dec6, err6); end
  endtask

  task automatic test_zero_protect();
    do_reset();
    wrenA = 1'b1; addrA = 3'd0;
    #1;
    checks++;
    if (ackAz !== 1'b1) begin errors++; $display("FAIL zp_ack: got %b want 1", ackAz); end
    tick();
    wrenA = 1'b0;
    checks++;
    if (decz !== 8'd0 || errz !== 1'b0) begin errors++; $display("FAIL zp_dec: got %b/%b want 00000000/0", decz, errz); end
    checks++;
    if (dec8 !== 8'b0000_0001) begin errors++; $display("FAIL zp_off_dec: got %b want 00000001", dec8); end
  endtask

  task automatic test_saturate_reset();
    do_reset();
    wrenA = 1'b1; addrA = 3'd4;
    wrenB = 1'b1; addrB = 3'd2;
    for (int i = 0; i < 300; i++) tick();
    checks++;
    if (cnt8 !== 8'd255) begin errors++; $display("FAIL sat_cnt: got %0d want 255", cnt8); end
    rst = 1'b1;
    #1;
    checks++;
    if ({ackA8, ackB8} !== 2'b00) begin errors++; $display("FAIL sat_rst_ack: got %b want 00", {ackA8, ackB8}); end
    tick();
    rst = 1'b0;
    checks++;
    if (cnt8 !== 8'd0 || dec8 !== 8'd0 || wsel8 !== 1'b0) begin
      errors++; $display("FAIL sat_rst_state: got cnt=%0d dec=%b wsel=%b want 0/00000000/0", cnt8, dec8, wsel8);
    end
    #1;
    checks++;
    if ({ackA8, ackB8} !== 2'b10) begin errors++; $display("FAIL sat_first_grant: got %b want 10", {ackA8, ackB8}); end
    tick();
    wrenA = 1'b0; wrenB = 1'b0;
    checks++;
    if (dec8 !== 8'b0001_0000 || wsel8 !== 1'b0 || cnt8 !== 8'd1) begin
      errors++; $display("FAIL sat_after: got dec=%b wsel=%b cnt=%0d want 00010000/0/1", dec8, wsel8, cnt8);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_single_a();
    test_conflict_drop();
    test_back_to_back();
    test_addr_err();
    test_zero_protect();
    test_saturate_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_wr_arb.md
Name: dec_wr_arb

Overview:
Parametrised register-file write-enable decoder with two write requesters sharing one register-file write port. Each cycle it arbitrates between port A and port B with a combinational accept. It decodes the winning address to a registered one-hot write-enable vector, and drives the data-mux select for the register-file write path. It replaces the fixed 3-to-8 single-port write decoder and adds non-power-of-2 depth, zero-register protection, error flagging and conflict statistics.

Parameters:
NREG, 8, number of registers (2..256, need not be a power of 2)
ADDR_W, clog2(NREG) (minimum 1), address width (derived, not overridden)
ZERO_PROTECT, 0, if 1, writes to register 0 are accepted but suppressed (hard-wired zero register)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
wrenA  input  1  port A write request
writeaddressA  input  ADDR_W  port A target register
ackA  output  1  port A request accepted this cycle (combinational)
wrenB  input  1  port B write request
writeaddressB  input  ADDR_W  port B target register
ackB  output  1  port B request accepted this cycle (combinational)
decOut  output  NREG  registered one-hot write enable to register file
wsel  output  1  registered; 0 = decOut belongs to port A data, 1 = port B
addr_err  output  1  registered one-cycle pulse: accepted address >= NREG
conflict_cnt  output  8  saturating count of cycles with both requests high

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Requester protocol:
  - A requester holds wren and address stable until it sees its ack high in the same cycle.
  - A requester may drop or change its request in the cycle after ack.
  - wren must not depend combinationally on ack.
- Arbitration state: 1-bit last-grant pointer lastB (0 = A granted last).
- Grant, combinational in cycle t:
  - Only wrenA high -> ackA=1.
  - Only wrenB high -> ackB=1.
  - Both high -> grant the port not granted last: lastB=1 grants A, lastB=0 grants B.
  - Neither high -> no ack.
  - ackA and ackB are never high together.
- lastB updates at the clock edge only when a grant occurs: 1 if B granted, 0 if A granted.
- Decode latency: exactly 1 cycle. For a grant in cycle t, at edge t+1:
  - decOut = one-hot(granted address); wsel = granted port.
  - decOut = all-zero if the address >= NREG, or if ZERO_PROTECT=1 and the address = 0.
  - addr_err = 1 only for address >= NREG. Zero-protect suppression is not an error.
  - The request is still acked and consumed in both suppression cases.
- No grant in cycle t -> decOut = 0, addr_err = 0, wsel holds its previous value.
- conflict_cnt increments by 1 each cycle wrenA and wrenB are both high. It holds at 255 and does not wrap.
- decOut is always zero or one-hot, never more than one bit set.
- Reset, rst high at an edge:
  - decOut=0, wsel=0, addr_err=0, lastB=1 (so port A wins the first conflict), conflict_cnt=0.
  - While rst is high, ackA and ackB are forced to 0 and nothing is consumed.
  - Any decOut in flight is cleared.
- Non-power-of-2 NREG: decode covers indices 0..NREG-1 only. Addresses NREG..2^ADDR_W-1 take the error path.

Test Plan:
- NREG=8: reset, then wrenA=1, addrA=5 for one cycle -> ackA=1 the same cycle; next cycle decOut=8'b00100000, wsel=0, addr_err=0; the cycle after, decOut=0.
- NREG=8: both requests held high, addrA=2, addrB=6, for 4 cycles with each port dropping its request after ack -> grant order A then B; decOut=00000100 (wsel=0) then 01000000 (wsel=1); conflict_cnt=1.
- NREG=8: both requests permanently high for 6 cycles -> acks alternate A,B,A,B,A,B; decOut strictly one-hot each cycle; conflict_cnt=6.
- NREG=6, ADDR_W=3: wrenB=1, addrB=7 -> ackB=1; next cycle decOut=000000, addr_err=1 for exactly one cycle. Then addrB=5 -> decOut=100000, addr_err=0.
- ZERO_PROTECT=1: wrenA=1, addrA=0 -> ackA=1; next cycle decOut=0, addr_err=0. With ZERO_PROTECT=0 the same stimulus -> decOut=00000001.
- Drive 300 conflict cycles then rst=1 for one edge while both requests are high -> conflict_cnt saturates at 255; during rst, ackA=ackB=0. After reset, decOut=0 and conflict_cnt=0, and the first conflict grants A.
